piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out loader that feeds the serial input (x_in) of the SISO shift register.
//   Accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per clock.
//   Flags the first and last bit of each word. Back-to-back words stream with no idle bubble.
// PARAMETERS
//   WIDTH      4   bits per parallel word (>=2)
//   LSB_FIRST  1   1: bit 0 is shifted out first; 0: bit WIDTH-1 is shifted out first
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   data_in      in   WIDTH  parallel word to serialize
//   valid_in     in   1      data_in is valid
//   ready_out    out  1      block can accept data_in this cycle
//   ser_out      out  1      serial bit; drives the downstream x_in
//   ser_valid    out  1      ser_out carries a data bit this cycle
//   frame_start  out  1      ser_out is the first bit of a word
//   word_done    out  1      ser_out is the last bit of a word
// BEHAVIOUR
//   Reset
//     - Asynchronous assertion: all registers clear immediately.
//     - ser_out=0, ser_valid=0, frame_start=0, word_done=0, shift reg=0, bit_cnt=0, state=IDLE.
//     - ready_out=0 while rst=1; ready_out=1 in the first cycle after release.
//   FSM
//     - IDLE:
//       - ready_out=1; ser_out=0; ser_valid=0.
//       - On accept, load the shift register, set bit_cnt=0, go to SHIFT.
//     - SHIFT:
//       - ser_valid=1; ser_out=current bit; bit_cnt counts 0..WIDTH-1.
//       - On bit_cnt==WIDTH-1 with accept: reload, set bit_cnt=0, stay in SHIFT.
//       - On bit_cnt==WIDTH-1 without accept: go to IDLE.
//   Handshake
//     - Accept = valid_in & ready_out at a rising clk edge.
//     - ready_out = !rst & (state==IDLE | (state==SHIFT & bit_cnt==WIDTH-1)); combinational from state.
//     - valid_in is ignored when ready_out=0; the word is not consumed and no side effect occurs.
//     - data_in is captured on the accept edge. Later changes to data_in have no effect on the word in flight.
//   Timing
//     - Latency: the first bit appears on ser_out in the cycle after the accept edge.
//     - A word occupies exactly WIDTH consecutive ser_valid cycles.
//     - frame_start=1 only when bit_cnt==0 in SHIFT.
//     - word_done=1 only when bit_cnt==WIDTH-1 in SHIFT.
//     - For WIDTH>=2, frame_start and word_done are never high together.
//   Arithmetic
//     - bit_cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
//     - Shift direction is selected by LSB_FIRST; the vacated bit fills with 0.
//   Boundaries
//     - Back-to-back: an accept on the word_done cycle makes the next word's bit 0 follow with no gap.
//       ser_valid stays high throughout.
//     - Reset mid-word: the word is abandoned, nothing is replayed, and the block returns to IDLE.
//     - When idle, ser_out is held at 0, so the downstream register shifts in zeros.
// TESTING
//   1. WIDTH=4, LSB_FIRST=1; accept 4'b1011 at edge T.
//      -> ser_out=1,1,0,1 in cycles T+1..T+4; frame_start at T+1; word_done at T+4; ready_out=0 at T+1..T+3.
//   2. valid_in held high with 4'hA then 4'h5.
//      -> ser_out=0,1,0,1,1,0,1,0 continuous; ser_valid high for 8 cycles; 2 frame_start, 2 word_done pulses.
//   3. LSB_FIRST=0; accept 4'b1000.
//      -> ser_out=1,0,0,0; then IDLE with ser_out=0, ser_valid=0, ready_out=1.
//   4. Accept 4'hF; pulse rst during the 2nd bit.
//      -> all outputs 0 immediately; no remaining bits are emitted; ready_out=1 the cycle after release.
//   5. During SHIFT at bit_cnt=1, drive valid_in=1 with 4'h3 and change data_in every cycle.
//      -> no accept until word_done; the word sent is data_in at that edge.
//   6. Chain to the 4-bit SISO register and accept 4'b1011.
//      -> after 4 shifts the register holds the 4 bits in order, with the first bit sent at the far end.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in / serial-out loader feeding the serial input of a SISO shift
// register. One WIDTH-bit word is taken per valid/ready handshake and is
// shifted out one bit per clock, with first/last-bit flags. A word accepted
// on the last-bit cycle of the previous word follows with no idle bubble.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no word in flight; ready_out=1, ser_out held at 0
// S_SHIFT | emitting bit bit_cnt of the current word (0..WIDTH-1)
//
// WIDTH must be at least 2 so the first-bit and last-bit cycles are
// distinct and bit_cnt has a non-zero width.

module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;
  logic             accept;

  // Handshake: ready is a pure function of state, forced low while in reset
  // so nothing can be accepted on the release edge's preceding cycle.
  assign last_bit  = (state == S_SHIFT) && (bit_cnt == CNT_LAST);
  assign ready_out = !rst && ((state == S_IDLE) || last_bit);
  assign accept    = valid_in && ready_out;

  // State register and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
    end
  end

  // Next-state: leave IDLE on accept; leave SHIFT only after the last bit
  // when no new word is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit && !accept) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath next value: load on accept, otherwise shift toward the output
  // end with zero fill; the register is cleared when the word finishes.
  always_comb begin
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    if (accept) begin
      shift_nxt = data_in;
      cnt_nxt   = '0;
    end else if (last_bit) begin
      shift_nxt = '0;
      cnt_nxt   = '0;
    end else if (state == S_SHIFT) begin
      if (LSB_FIRST) shift_nxt = shift_reg >> 1;
      else           shift_nxt = shift_reg << 1;
      cnt_nxt = bit_cnt + CNT_ONE;
    end
  end

  // Outputs decoded from state; ser_out is held at 0 outside SHIFT so the
  // downstream register shifts in zeros while idle.
  always_comb begin
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    word_done   = 1'b0;
    if (state == S_SHIFT) begin
      ser_valid   = 1'b1;
      ser_out     = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
      frame_start = (bit_cnt == '0);
      word_done   = (bit_cnt == CNT_LAST);
    end
  end

endmodule
